// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and state type for the 1-to-8 capture demux
package demux_pkg;
  localparam int NUM_LANES = 8;
  localparam int SEL_WIDTH = 3;
  localparam logic [NUM_LANES-1:0] MASK_FULL = '1;
  typedef enum logic {FILL, HOLD} state_e;
endpackage

// File: rtl/demux_lane_decoder.sv
// demux_lane_decoder: sel_i -> one-hot lane write enable we_o, all zero unless en_i
module demux_lane_decoder
  import demux_pkg::*;
(
  input  logic [SEL_WIDTH-1:0] sel_i,
  input  logic                 en_i,
  output logic [NUM_LANES-1:0] we_o
);
  always_comb we_o = en_i ? NUM_LANES'(1) << sel_i : '0;
endmodule

// File: rtl/demux_capture_8.sv
// demux_capture_8: steers serial samples into 8 lanes (select or auto pointer), releases full word via valid/ready
module demux_capture_8
  import demux_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_WIDTH-1:0] select,
  input  logic                 auto_mode,
  input  logic                 flush,
  output logic [NUM_LANES-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_LANES-1:0] lane_mask,
  output logic [SEL_WIDTH-1:0] ptr
);
  state_e               state_q, state_d;
  logic                 in_ready_q;
  logic [NUM_LANES-1:0] out_q, out_d, mask_q, mask_d, we;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d, tgt;
  logic                 accept, rel;
  // in_ready_q is only ever high in FILL, so it alone qualifies an accept
  assign accept = in_valid && in_ready_q && !flush;
  assign tgt    = auto_mode ? ptr_q : select;
  assign rel    = state_q == HOLD && out_ready;
  demux_lane_decoder u_dec (.sel_i(tgt), .en_i(accept), .we_o(we));
  always_comb begin
    out_d   = out_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    state_d = state_q;
    if (flush || rel) begin
      mask_d  = '0;
      ptr_d   = '0;
      state_d = FILL;
    end else if (accept) begin
      out_d   = (out_q & ~we) | (in ? we : '0);
      mask_d  = mask_q | we;
      ptr_d   = auto_mode ? ptr_q + SEL_WIDTH'(1) : ptr_q;
      state_d = mask_d == MASK_FULL ? HOLD : FILL;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= FILL;
      in_ready_q <= 1'b0;
      out_q      <= '0;
      mask_q     <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= state_d == FILL;
      out_q      <= out_d;
      mask_q     <= mask_d;
      ptr_q      <= ptr_d;
    end
  assign in_ready  = in_ready_q;
  assign out_valid = state_q == HOLD;
  assign out       = out_q;
  assign lane_mask = mask_q;
  assign ptr       = ptr_q;
endmodule

// File: tb/tb_demux_capture_8.sv
// tb_demux_capture_8: scoreboard bench for demux_capture_8 with a behavioural lane-set model
module tb_demux_capture_8;
  logic clk = 0, rst_n = 0, din = 0, in_valid = 0, auto_mode = 0, flush = 0, out_ready = 0;
  logic [2:0] select = 0;
  logic in_ready, out_valid;
  logic [7:0] out, lane_mask;
  logic [2:0] ptr;
  int vectors = 0, miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_out, m_mask;
  int m_ptr;
  bit m_hold, m_ready;

  demux_capture_8 dut (.clk(clk), .rst_n(rst_n), .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .auto_mode(auto_mode), .flush(flush), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .lane_mask(lane_mask), .ptr(ptr));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Reference: a set of eight lanes, a record of which were written, a wrapping pointer
  always @(posedge clk or negedge rst_n) begin
    int lane;
    if (!rst_n) begin
      m_out = 0; m_mask = 0; m_ptr = 0; m_hold = 0; m_ready = 0;
      exp_q.delete();
    end else if (flush) begin
      if (m_hold) exp_q.delete();
      m_mask = 0; m_ptr = 0; m_hold = 0; m_ready = 1;
    end else if (m_hold) begin
      if (out_ready) begin m_hold = 0; m_mask = 0; m_ptr = 0; end
      m_ready = !m_hold;
    end else begin
      if (m_ready && in_valid) begin
        lane = auto_mode ? m_ptr : int'(select);
        m_out[lane] = din;
        m_mask[lane] = 1'b1;
        if (auto_mode) m_ptr = (m_ptr + 1) % 8;
        if (m_mask == 8'hFF) begin m_hold = 1; exp_q.push_back(m_out); end
      end
      m_ready = !m_hold;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, m_hold);
    chk("lane_mask", lane_mask, m_mask);
    chk("ptr", ptr, m_ptr);
    chk("out", out, m_out);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL word released with none expected, got %0h", out);
      end else chk("word", out, exp_q.pop_front());
    end
  end

  task automatic step(logic v, logic d, logic [2:0] s, logic am, logic fl, logic r);
    in_valid = v; din = d; select = s; auto_mode = am; flush = fl; out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic release_word();
    step(0, 0, 0, 0, 0, 1);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_mask", lane_mask, 0);
    chk("rel_ptr", ptr, 0);
  endtask

  initial begin
    logic [7:0] bits;
    #12 rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_reset", in_ready, 1);
    // auto fill 1,0,1,1,0,0,1,0
    bits = 8'b01001101;
    for (int i = 0; i < 8; i++) step(1, bits[i], 0, 1, 0, 0);
    chk("t1_out", out, 8'h4D); chk("t1_valid", out_valid, 1);
    chk("t1_ready", in_ready, 0); chk("t1_ptr", ptr, 0);
    release_word();
    // addressed 7..0, ones on even lanes, then stall
    for (int s = 7; s >= 0; s--) step(1, s % 2 == 0, 3'(s), 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1'($urandom), 3'($urandom), 0, 0, 0);
      chk("t2_stable", out, 8'h55); chk("t2_valid", out_valid, 1);
    end
    release_word();
    // lane 3 rewritten: nine accepts needed
    step(1, 1, 3, 0, 0, 0);
    step(1, 0, 3, 0, 0, 0);
    for (int s = 0; s < 8; s++) if (s != 3) begin
      chk("t3_not_yet", out_valid, 0);
      step(1, 1, 3'(s), 0, 0, 0);
    end
    chk("t3_out", out, 8'hF7); chk("t3_valid", out_valid, 1);
    release_word();
    // flush overrides accept
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    chk("t4_mask", lane_mask, 0); chk("t4_ptr", ptr, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 0, 0);
    chk("t4_not_yet", out_valid, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("t4_valid", out_valid, 1); chk("t4_out", out, 8'h00);
    release_word();
    // async reset mid-fill
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0, 0);
    chk("t5_mask", lane_mask, 8'h0F);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("t5_out", out, 0); chk("t5_mask0", lane_mask, 0); chk("t5_ptr", ptr, 0);
    chk("t5_valid", out_valid, 0); chk("t5_ready", in_ready, 0);
    @(posedge clk); #1 rst_n = 1;
    chk("t5_ready_rel", in_ready, 0);
    @(posedge clk); #1;
    chk("t5_ready_edge", in_ready, 1);
    // auto -> addressed mid-fill
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, 0);
    chk("t6_ptr3", ptr, 3);
    for (int s = 3; s < 8; s++) begin
      chk("t6_not_yet", out_valid, 0);
      step(1, 0, 3'(s), 0, 0, 0);
      chk("t6_ptr_hold", ptr, 3);
    end
    chk("t6_valid", out_valid, 1); chk("t6_out", out, 8'h07);
    release_word();
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(3) != 0, 1'($urandom), 3'($urandom), $urandom_range(7) != 0,
           $urandom_range(60) == 0, $urandom_range(2) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
